lsq_param: RTL and testbench
============================

Name: lsq_param

Overview:
- Parametrised load/store queue for the out-of-order RISC-V core. Successor to the fixed-size LSQ.
- Entries are allocated in program order at dispatch. Each entry's effective address is filled in by the LSU, matched by PC.
- Resolved loads are searched against older resolved stores for store-to-load forwarding.
- Retired entries drain in order from the head, emitting one memory write per retired store.
- Sits between dispatch, the LSU address stage, the ROB retire ports and the data memory write port.

Parameters:
- DEPTH, 16, number of queue entries; power of two, at least 2
- DW, 32, store data and load data width; must be 32 in this generation
- ROBW, 6, ROB index width
- NRET, 2, number of retire ports

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dis_valid  in  1  dispatch request
- dis_pc  in  32  PC of the dispatched instruction (entry tag)
- dis_is_load  in  1  instruction is a load
- dis_is_store  in  1  instruction is a store
- dis_size  in  1  0 = word, 1 = byte
- dis_sw_data  in  DW  store data
- dis_rob  in  ROBW  ROB index
- dis_dest  in  6  physical destination register
- full  out  1  queue full; dispatch is ignored while high
- count  out  $clog2(DEPTH)+1  number of occupied entries
- lsu_valid  in  1  address update request
- lsu_pc  in  32  PC tag for the address update
- lsu_addr  in  32  effective address
- out_valid  out  1  result valid
- out_pc  out  32  PC of the result entry
- out_rob  out  ROBW  ROB index of the result entry
- out_dest  out  6  destination register of the result entry
- out_addr  out  32  address of the result entry
- out_data  out  DW  forwarded load data
- out_fwd  out  1  load was satisfied from the LSQ
- out_is_store  out  1  result entry is a store
- ret_valid  in  NRET  per-port retire strobe
- ret_pc  in  32*NRET  retiring PCs; port i occupies bits [32i+31:32i]
- mem_wr_valid  out  1  data memory write strobe
- mem_wr_addr  out  32  data memory write address
- mem_wr_data  out  DW  data memory write data
- mem_wr_size  out  1  0 = word, 1 = byte

Behaviour:
- Reset
  - Synchronous, active-high. Clears head, tail, count and all valid, addr_valid and retired bits.
  - All outputs read 0 in the cycle after rst; `full` = 0.
  - Reset asserted mid-operation discards every entry. No `mem_wr_valid` is emitted for pending retired stores.
- Storage
  - Circular buffer with head and tail pointers. Pointers wrap from DEPTH-1 to 0.
  - `count` is registered. `full` = (count == DEPTH).
- Dispatch
  - Allocate at tail when dis_valid && !full && (dis_is_load ^ dis_is_store).
  - Any other combination is ignored with no state change.
- Address update
  - When lsu_valid is high, CAM on lsu_pc across valid entries; the oldest match from head wins.
  - The matching entry latches the address and sets addr_valid.
  - No match: ignored, no output.
- Result (1-cycle latency)
  - The cycle after an accepted address update, out_valid = 1 with the entry's pc, rob, dest and addr.
  - Store result: out_is_store = 1, out_fwd = 0, out_data = 0.
  - Load result: scan the older entries, head up to the load. Take the youngest older store with addr_valid and a matching address:
    - word store with word-aligned address equal to the load's: out_fwd = 1, out_data = store data;
    - byte store with exact address equal to the load's: out_fwd = 1, out_data = {24'b0, data[7:0]};
    - otherwise out_fwd = 0, out_data = 0.
  - Stores whose address is still unresolved are skipped; hazard detection is the LSU's job.
  - out_valid is a single-cycle pulse; all out_* fields are zero when out_valid = 0.
- Retire
  - Each asserted ret port CAMs its PC and sets the matching entry's retired bit. Multiple ports may hit in the same cycle.
- Drain
  - At most one pop per cycle, from head, when the head entry is valid && retired.
  - A popped store drives mem_wr_valid = 1 with its addr/data/size the next cycle. A popped load drains silently.
- Simultaneous events
  - Dispatch and pop in the same cycle: count is unchanged.
  - `full` is evaluated from the registered count, so a pop does not admit a dispatch in that same cycle.
  - LSU update and retire of the same entry in the same cycle: both are applied.
  - Address update and pop of the same entry in the same cycle: the result is still produced.

Test Plan:
- Reset, then dispatch 4 entries: store pc 0x10 data 0x23, store pc 0x14 data 0x46, load pc 0x18, load pc 0x1C, all word-sized -> count = 4, full = 0.
- LSU pc 0x10 addr 0x4, pc 0x14 addr 0x8, pc 0x18 addr 0x4, pc 0x1C addr 0x8 -> loads return out_fwd = 1 with out_data 0x23 and 0x46; stores return out_is_store = 1; each result appears one cycle after its LSU input.
- Byte store 0x1FF to addr 0x5, then word load addr 0x4 -> out_fwd = 0. Byte load addr 0x5 -> out_data = 0xFF.
- Dispatch DEPTH entries -> full = 1 and the next dispatch is ignored. Retire the head and let it pop -> full falls and the pointer wraps correctly.
- Retire pcs 0x14 and 0x10 on both ports in the same cycle -> two consecutive mem_wr pulses (0x4/0x23, then 0x8/0x46) in program order.
- Assert rst with 3 retired stores pending -> no mem_wr_valid pulse, and count = 0 the next cycle.

Source files
------------

// File: rtl/lsq_param.sv
// lsq_param: parametrised load/store queue.
//
// Entries are allocated in program order at dispatch and tagged by PC. The
// LSU fills in effective addresses by PC lookup; each accepted address update
// produces one registered result the next cycle. A resolved load is checked
// against older resolved stores for store-to-load forwarding. Retire ports
// mark entries retired by PC, and retired entries drain in order from the
// head, one per cycle. A drained store produces one data-memory write.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   dis_*                        dispatch request and entry payload
//   full, count                  occupancy (registered)
//   lsu_valid/lsu_pc/lsu_addr    address update, matched by PC
//   out_*                        single-cycle result pulse for an address update
//   ret_valid/ret_pc             NRET retire ports, port i in ret_pc[32i+31:32i]
//   mem_wr_*                     data-memory write for each drained store
//
// Handshake: no back-pressure anywhere. Dispatch is accepted in a cycle when
// dis_valid is high, full is low and exactly one of dis_is_load/dis_is_store
// is set; otherwise it is dropped. lsu_valid, ret_valid, out_valid and
// mem_wr_valid are one-cycle strobes with no ready.
module lsq_param #(
  parameter int DEPTH = 16,
  parameter int DW    = 32,
  parameter int ROBW  = 6,
  parameter int NRET  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dis_valid,
  input  logic [31:0]             dis_pc,
  input  logic                    dis_is_load,
  input  logic                    dis_is_store,
  input  logic                    dis_size,
  input  logic [DW-1:0]           dis_sw_data,
  input  logic [ROBW-1:0]         dis_rob,
  input  logic [5:0]              dis_dest,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  input  logic                    lsu_valid,
  input  logic [31:0]             lsu_pc,
  input  logic [31:0]             lsu_addr,
  output logic                    out_valid,
  output logic [31:0]             out_pc,
  output logic [ROBW-1:0]         out_rob,
  output logic [5:0]              out_dest,
  output logic [31:0]             out_addr,
  output logic [DW-1:0]           out_data,
  output logic                    out_fwd,
  output logic                    out_is_store,
  input  logic [NRET-1:0]         ret_valid,
  input  logic [32*NRET-1:0]      ret_pc,
  output logic                    mem_wr_valid,
  output logic [31:0]             mem_wr_addr,
  output logic [DW-1:0]           mem_wr_data,
  output logic                    mem_wr_size
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Per-entry state
  logic [DEPTH-1:0] valid_q, addr_valid_q, retired_q, is_store_q, size_q;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [ROBW-1:0]  rob_q  [DEPTH];
  logic [5:0]       dest_q [DEPTH];

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  // Output registers
  logic            out_valid_q, out_fwd_q, out_is_store_q;
  logic [31:0]     out_pc_q, out_addr_q;
  logic [ROBW-1:0] out_rob_q;
  logic [5:0]      out_dest_q;
  logic [DW-1:0]   out_data_q;
  logic            mem_wr_valid_q, mem_wr_size_q;
  logic [31:0]     mem_wr_addr_q;
  logic [DW-1:0]   mem_wr_data_q;

  // slot[k] is the physical index of the k-th oldest entry position.
  logic [PW-1:0] slot [DEPTH];
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      slot[k] = head_q + PW'(k);
    end
  end

  logic dis_ok, pop;
  assign full   = (count_q == CW'(DEPTH));
  assign count  = count_q;
  assign dis_ok = dis_valid && !full && (dis_is_load ^ dis_is_store);
  assign pop    = valid_q[head_q] && retired_q[head_q];

  // Address-update CAM: scan youngest to oldest so the oldest match wins.
  logic          lsu_hit;
  logic [PW-1:0] lsu_idx;
  always_comb begin
    lsu_hit = 1'b0;
    lsu_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (lsu_valid && valid_q[slot[k]] && (pc_q[slot[k]] == lsu_pc)) begin
        lsu_hit = 1'b1;
        lsu_idx = slot[k];
      end
    end
  end

  // Forwarding search: among entries strictly older than the load, scan
  // oldest to youngest so the youngest resolved store in the same word wins.
  // Stores with unresolved addresses are simply skipped.
  logic [PW-1:0] lsu_age;
  logic          fwd_hit;
  logic [PW-1:0] fwd_idx;
  always_comb begin
    lsu_age = lsu_idx - head_q;
    fwd_hit = 1'b0;
    fwd_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW'(k) < lsu_age) && valid_q[slot[k]] && is_store_q[slot[k]] &&
          addr_valid_q[slot[k]] && (addr_q[slot[k]][31:2] == lsu_addr[31:2])) begin
        fwd_hit = 1'b1;
        fwd_idx = slot[k];
      end
    end
  end

  // The youngest same-word store decides: a word store forwards whole, a
  // byte store only forwards to a load at its exact byte address.
  logic          res_fwd;
  logic [DW-1:0] res_data;
  always_comb begin
    res_fwd  = 1'b0;
    res_data = '0;
    if (!is_store_q[lsu_idx] && fwd_hit) begin
      if (!size_q[fwd_idx]) begin
        res_fwd  = 1'b1;
        res_data = data_q[fwd_idx];
      end else if (addr_q[fwd_idx] == lsu_addr) begin
        res_fwd  = 1'b1;
        res_data = {{(DW-8){1'b0}}, data_q[fwd_idx][7:0]};
      end
    end
  end

  // Retire CAM per port: oldest valid, not-yet-retired entry with that PC.
  logic [NRET-1:0] ret_hit;
  logic [PW-1:0]   ret_idx [NRET];
  always_comb begin
    for (int p = 0; p < NRET; p++) begin
      ret_hit[p] = 1'b0;
      ret_idx[p] = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ret_valid[p] && valid_q[slot[k]] && !retired_q[slot[k]] &&
            (pc_q[slot[k]] == ret_pc[32*p +: 32])) begin
          ret_hit[p] = 1'b1;
          ret_idx[p] = slot[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      addr_valid_q   <= '0;
      retired_q      <= '0;
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_rob_q      <= '0;
      out_dest_q     <= '0;
      out_addr_q     <= '0;
      out_data_q     <= '0;
      out_fwd_q      <= 1'b0;
      out_is_store_q <= 1'b0;
      mem_wr_valid_q <= 1'b0;
      mem_wr_addr_q  <= '0;
      mem_wr_data_q  <= '0;
      mem_wr_size_q  <= 1'b0;
    end else begin
      // Result pulse; fields forced to zero when there is no result.
      out_valid_q    <= lsu_hit;
      out_pc_q       <= lsu_hit ? pc_q[lsu_idx]   : '0;
      out_rob_q      <= lsu_hit ? rob_q[lsu_idx]  : '0;
      out_dest_q     <= lsu_hit ? dest_q[lsu_idx] : '0;
      out_addr_q     <= lsu_hit ? lsu_addr        : '0;
      out_data_q     <= lsu_hit ? res_data        : '0;
      out_fwd_q      <= lsu_hit && res_fwd;
      out_is_store_q <= lsu_hit && is_store_q[lsu_idx];

      // Memory write for a drained store; loads drain silently.
      mem_wr_valid_q <= pop && is_store_q[head_q];
      mem_wr_addr_q  <= (pop && is_store_q[head_q]) ? addr_q[head_q] : '0;
      mem_wr_data_q  <= (pop && is_store_q[head_q]) ? data_q[head_q] : '0;
      mem_wr_size_q  <= pop && is_store_q[head_q] && size_q[head_q];

      if (dis_ok) begin
        valid_q[tail_q]      <= 1'b1;
        addr_valid_q[tail_q] <= 1'b0;
        retired_q[tail_q]    <= 1'b0;
        is_store_q[tail_q]   <= dis_is_store;
        size_q[tail_q]       <= dis_size;
        pc_q[tail_q]         <= dis_pc;
        data_q[tail_q]       <= dis_sw_data;
        rob_q[tail_q]        <= dis_rob;
        dest_q[tail_q]       <= dis_dest;
        tail_q               <= tail_q + PW'(1);
      end

      if (lsu_hit) begin
        addr_q[lsu_idx]       <= lsu_addr;
        addr_valid_q[lsu_idx] <= 1'b1;
      end

      for (int p = 0; p < NRET; p++) begin
        if (ret_hit[p]) retired_q[ret_idx[p]] <= 1'b1;
      end

      // Pop last so clearing the head overrides any same-cycle update to it.
      if (pop) begin
        valid_q[head_q]      <= 1'b0;
        addr_valid_q[head_q] <= 1'b0;
        retired_q[head_q]    <= 1'b0;
        head_q               <= head_q + PW'(1);
      end

      case ({dis_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_rob      = out_rob_q;
  assign out_dest     = out_dest_q;
  assign out_addr     = out_addr_q;
  assign out_data     = out_data_q;
  assign out_fwd      = out_fwd_q;
  assign out_is_store = out_is_store_q;
  assign mem_wr_valid = mem_wr_valid_q;
  assign mem_wr_addr  = mem_wr_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign mem_wr_size  = mem_wr_size_q;

endmodule

// File: tb/tb_lsq_param.sv
// Directed testbench for lsq_param (DEPTH=16, DW=32, ROBW=6, NRET=2).
module tb_lsq_param;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dis_valid = 1'b0;
  logic [31:0] dis_pc = '0;
  logic        dis_is_load = 1'b0;
  logic        dis_is_store = 1'b0;
  logic        dis_size = 1'b0;
  logic [31:0] dis_sw_data = '0;
  logic [5:0]  dis_rob = '0;
  logic [5:0]  dis_dest = '0;
  logic        full;
  logic [4:0]  count;
  logic        lsu_valid = 1'b0;
  logic [31:0] lsu_pc = '0;
  logic [31:0] lsu_addr = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [5:0]  out_rob;
  logic [5:0]  out_dest;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        out_fwd;
  logic        out_is_store;
  logic [1:0]  ret_valid = '0;
  logic [63:0] ret_pc = '0;
  logic        mem_wr_valid;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_size;

  lsq_param #(.DEPTH(16), .DW(32), .ROBW(6), .NRET(2)) dut (
    .clk(clk), .rst(rst),
    .dis_valid(dis_valid), .dis_pc(dis_pc), .dis_is_load(dis_is_load),
    .dis_is_store(dis_is_store), .dis_size(dis_size), .dis_sw_data(dis_sw_data),
    .dis_rob(dis_rob), .dis_dest(dis_dest),
    .full(full), .count(count),
    .lsu_valid(lsu_valid), .lsu_pc(lsu_pc), .lsu_addr(lsu_addr),
    .out_valid(out_valid), .out_pc(out_pc), .out_rob(out_rob), .out_dest(out_dest),
    .out_addr(out_addr), .out_data(out_data), .out_fwd(out_fwd),
    .out_is_store(out_is_store),
    .ret_valid(ret_valid), .ret_pc(ret_pc),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_size(mem_wr_size)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  int total = 0;
  int bad = 0;
  logic [127:0] exp_q[$];   // {2'b0, cycle[15:0], pc, rob, dest, addr, data, fwd, is_store}
  logic [64:0]  mem_q[$];   // {addr, data, size}

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack_out(input logic [15:0] c, input logic [31:0] pc,
      input logic [5:0] rob, input logic [5:0] dest, input logic [31:0] addr,
      input logic [31:0] data, input logic fwd, input logic st);
    return {2'b00, c, pc, rob, dest, addr, data, fwd, st};
  endfunction

  // Monitor: compare every result / write pulse against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("out_unexpected", 128'(out_pc), 128'(0));
        else chk("out_result",
                 pack_out(cyc[15:0], out_pc, out_rob, out_dest, out_addr, out_data, out_fwd, out_is_store),
                 exp_q.pop_front());
      end else begin
        chk("out_idle_zero", 128'({out_pc, out_rob, out_dest, out_addr, out_data, out_fwd, out_is_store}), 128'(0));
      end
      if (mem_wr_valid) begin
        if (mem_q.size() == 0) chk("mem_unexpected", 128'(mem_wr_addr), 128'(0));
        else chk("mem_write", 128'({mem_wr_addr, mem_wr_data, mem_wr_size}), 128'(mem_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [31:0] pc, input logic ld, input logic st, input logic sz,
                          input logic [31:0] data, input logic [5:0] rob, input logic [5:0] dest);
    dis_valid = 1'b1; dis_pc = pc; dis_is_load = ld; dis_is_store = st;
    dis_size = sz; dis_sw_data = data; dis_rob = rob; dis_dest = dest;
    tick();
    dis_valid = 1'b0; dis_is_load = 1'b0; dis_is_store = 1'b0;
  endtask

  // Address update; when a result is expected it is due exactly one cycle later.
  task automatic lsu(input logic [31:0] pc, input logic [31:0] addr, input logic expect_out,
                     input logic [5:0] rob, input logic [5:0] dest, input logic [31:0] data,
                     input logic fwd, input logic st);
    lsu_valid = 1'b1; lsu_pc = pc; lsu_addr = addr;
    if (expect_out) exp_q.push_back(pack_out(16'(cyc + 1), pc, rob, dest, addr, data, fwd, st));
    tick();
    lsu_valid = 1'b0;
  endtask

  task automatic retire(input logic [1:0] v, input logic [31:0] pc1, input logic [31:0] pc0);
    ret_valid = v; ret_pc = {pc1, pc0};
    tick();
    ret_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("reset_count", 128'(count), 128'(0));
    chk("reset_full", 128'(full), 128'(0));
    chk("reset_outs", 128'({out_valid, mem_wr_valid, out_pc, out_data, mem_wr_addr}), 128'(0));

    // Four word entries, then address updates with forwarding
    dispatch(32'h10, 0, 1, 0, 32'h23, 6'd1, 6'd0);
    dispatch(32'h14, 0, 1, 0, 32'h46, 6'd2, 6'd0);
    dispatch(32'h18, 1, 0, 0, 32'h0,  6'd3, 6'd5);
    dispatch(32'h1C, 1, 0, 0, 32'h0,  6'd4, 6'd6);
    chk("count_4", 128'(count), 128'(4));
    chk("full_4", 128'(full), 128'(0));
    lsu(32'h10, 32'h4, 1, 6'd1, 6'd0, 32'h0,  0, 1);
    lsu(32'h14, 32'h8, 1, 6'd2, 6'd0, 32'h0,  0, 1);
    lsu(32'h18, 32'h4, 1, 6'd3, 6'd5, 32'h23, 1, 0);
    lsu(32'h1C, 32'h8, 1, 6'd4, 6'd6, 32'h46, 1, 0);
    tick();
    chk("count_after_lsu", 128'(count), 128'(4));

    // Retire both stores in one cycle (port1 0x10, port0 0x14): in-order drain
    mem_q.push_back({32'h4, 32'h23, 1'b0});
    mem_q.push_back({32'h8, 32'h46, 1'b0});
    retire(2'b11, 32'h10, 32'h14);
    chk("mem_not_yet", 128'(mem_wr_valid), 128'(0));
    tick();
    chk("mem_pulse1", 128'({mem_wr_valid, mem_wr_addr}), 128'({1'b1, 32'h4}));
    tick();
    chk("mem_pulse2", 128'({mem_wr_valid, mem_wr_addr}), 128'({1'b1, 32'h8}));
    retire(2'b11, 32'h18, 32'h1C);
    tick(); tick(); tick();
    chk("drained_count", 128'(count), 128'(0));

    // Byte store forwarding rules; malformed dispatches are dropped
    dispatch(32'h20, 0, 1, 1, 32'h1FF, 6'd7, 6'd0);
    dispatch(32'h24, 1, 0, 0, 32'h0,   6'd8, 6'd9);
    dispatch(32'h30, 1, 1, 0, 32'h0,   6'd9, 6'd9);
    dispatch(32'h34, 0, 0, 0, 32'h0,   6'd9, 6'd9);
    dispatch(32'h28, 1, 0, 1, 32'h0,   6'd9, 6'd10);
    chk("count_bad_dispatch", 128'(count), 128'(3));
    lsu(32'h20, 32'h5, 1, 6'd7, 6'd0,  32'h0,  0, 1);
    lsu(32'h24, 32'h4, 1, 6'd8, 6'd9,  32'h0,  0, 0);
    lsu(32'h28, 32'h5, 1, 6'd9, 6'd10, 32'hFF, 1, 0);
    lsu(32'h99, 32'h0, 0, 6'd0, 6'd0,  32'h0,  0, 0);
    lsu(32'h30, 32'h0, 0, 6'd0, 6'd0,  32'h0,  0, 0);
    tick(); tick();

    // Fill to DEPTH, reject overflow, pop one and wrap the tail
    do_reset();
    chk("reset2_count", 128'({full, count}), 128'(0));
    for (int i = 0; i < 16; i++) dispatch(32'h100 + 32'(4 * i), 1, 0, 0, 32'h0, 6'(i), 6'(i));
    chk("full_count", 128'(count), 128'(16));
    chk("full_flag", 128'(full), 128'(1));
    dispatch(32'h200, 1, 0, 0, 32'h0, 6'd30, 6'd30);
    chk("full_ignored", 128'(count), 128'(16));
    lsu(32'h200, 32'h0, 0, 6'd0, 6'd0, 32'h0, 0, 0);
    retire(2'b01, 32'h0, 32'h100);
    tick();
    chk("pop_count", 128'(count), 128'(15));
    chk("pop_full", 128'(full), 128'(0));
    dispatch(32'h300, 1, 0, 0, 32'h0, 6'd20, 6'd21);
    chk("wrap_count", 128'({full, count}), 128'({1'b1, 5'd16}));
    lsu(32'h300, 32'h40, 1, 6'd20, 6'd21, 32'h0, 0, 0);
    lsu(32'h104, 32'h44, 1, 6'd1,  6'd1,  32'h0, 0, 0);
    tick();

    // Reset with three retired stores pending: no write may escape
    do_reset();
    dispatch(32'h40, 1, 0, 0, 32'h0,  6'd1, 6'd2);
    dispatch(32'h44, 0, 1, 0, 32'hA1, 6'd2, 6'd0);
    dispatch(32'h48, 0, 1, 0, 32'hB2, 6'd3, 6'd0);
    dispatch(32'h4C, 0, 1, 0, 32'hC3, 6'd4, 6'd0);
    lsu(32'h44, 32'h100, 1, 6'd2, 6'd0, 32'h0, 0, 1);
    lsu(32'h48, 32'h104, 1, 6'd3, 6'd0, 32'h0, 0, 1);
    lsu(32'h4C, 32'h108, 1, 6'd4, 6'd0, 32'h0, 0, 1);
    retire(2'b11, 32'h44, 32'h48);
    retire(2'b01, 32'h0, 32'h4C);
    tick();
    chk("blocked_by_load", 128'({mem_wr_valid, count}), 128'({1'b0, 5'd4}));
    retire(2'b01, 32'h0, 32'h40);
    tick();
    chk("pending_count", 128'(count), 128'(3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_no_write", 128'(mem_wr_valid), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    tick(); tick(); tick();
    chk("rst_count_later", 128'(count), 128'(0));

    chk("out_queue_empty", 128'(exp_q.size()), 128'(0));
    chk("mem_queue_empty", 128'(mem_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
